// File: rtl/avalon_regbank_responder.sv
// Avalon-MM register-bank responder; AVS_ID_REG_EN makes address 0 a read-only ID.
// Latency: WAIT_CYCLES stall cycles per transfer; readdatavalid_o READ_LATENCY edges after acceptance.
// Backpressure: waitrequest_o holds each request; the read pipeline never stalls.
module avalon_regbank_responder #(
  parameter int ADDRSIZE     = 3,
  parameter int DATASIZE     = 16,
  parameter int WAIT_CYCLES  = 1,
  parameter int READ_LATENCY = 2,
  parameter logic [DATASIZE-1:0] ID_VALUE = DATASIZE'(16'hCAFE)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [ADDRSIZE-1:0]   address_i,
  input  logic [DATASIZE/8-1:0] byteenable_i,
  input  logic                  read_i,
  input  logic                  write_i,
  input  logic [DATASIZE-1:0]   writedata_i,
  output logic                  waitrequest_o,
  output logic [DATASIZE-1:0]   readdata_o,
  output logic                  readdatavalid_o,
  output logic                  err_o
);

  localparam int NREGS  = 1 << ADDRSIZE;
  localparam int NBYTES = DATASIZE / 8;
  localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, STALL, ACCEPT} phase_t;

  phase_t                phase;
  logic [3:0]            wcnt;
  logic [3:0]            wcnt_nxt;
  logic                  req;
  logic                  accept;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  wr_ok;
  logic [DATASIZE-1:0]   lane_mask;
  logic [DATASIZE-1:0]   rd_word;
  logic [DATASIZE-1:0]   regs [NREGS];
  logic [READ_LATENCY-1:0] vld_pipe;
  logic [DATASIZE-1:0]   dat_pipe [READ_LATENCY];

  // wcnt is the state register; the phase is decoded from it and the live request
  always_comb begin
    req      = read_i | write_i;
    phase    = IDLE;
    wcnt_nxt = 4'd0;
    if (req) begin
      if (wcnt != WAIT_LIM) begin
        phase    = STALL;
        wcnt_nxt = wcnt + 4'd1;
      end else begin
        phase    = ACCEPT;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wcnt <= 4'd0;
    end else begin
      wcnt <= wcnt_nxt;
    end
  end

  assign waitrequest_o = (phase == STALL);
  assign accept        = (phase == ACCEPT);
  assign rd_acc        = accept & read_i & ~write_i;
  assign wr_acc        = accept & write_i & ~read_i;

`ifdef AVS_ID_REG_EN
  assign wr_ok = wr_acc && (address_i != '0);
`else
  assign wr_ok = wr_acc;
`endif

  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < NBYTES; k++) begin
      lane_mask[8*k +: 8] = {8{byteenable_i[k]}};
    end
    rd_word = regs[address_i];
`ifdef AVS_ID_REG_EN
    if (address_i == '0) begin
      rd_word = ID_VALUE;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      err_o <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (accept && read_i && write_i) begin
        err_o <= 1'b1;
      end
      if (wr_ok) begin
        for (int k = 0; k < NBYTES; k++) begin
          if (byteenable_i[k]) begin
            regs[address_i][8*k +: 8] <= writedata_i[8*k +: 8];
          end
        end
      end
    end
  end

  // Data stages stay zero unless they carry a read, so readdata_o idles at 0
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      vld_pipe <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        dat_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= rd_acc;
      dat_pipe[0] <= rd_acc ? (rd_word & lane_mask) : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign readdatavalid_o = vld_pipe[READ_LATENCY-1];
  assign readdata_o      = dat_pipe[READ_LATENCY-1];

endmodule
